// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Single-port 32-bit data memory for a processor. Each access is
//            accepted in IDLE and then held through WAIT_CYCLES wait states.
//            A one-cycle RESP then returns ack, together with rdata and err.
//            Misaligned or out-of-range accesses fault. A faulting access
//            never writes the array and returns rdata=0.
// Ports    : clk            - clock, rising edge
//            reset          - asynchronous reset, active low
//            req/we         - request strobe, 1=write 0=read
//            addr/wdata     - byte address (word index = addr[31:2]) / write data
//            ack            - one-cycle response strobe
//            rdata/err      - read data / fault flag, zero when ack=0
//            busy           - high whenever the FSM is not IDLE
//            pass/fail      - sticky self-check trap flags
// Config   : `define DMEM_TRAP_EN enables the pass/fail trap logic.
//            When it is undefined, pass and fail are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic        pass,
  output logic        fail
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Array contents are deliberately never reset.
  logic [31:0] mem_q [DEPTH];

  // Describes the access that completes on this edge. With zero wait states
  // it is taken straight from the ports; otherwise it uses the latched copy.
  logic             enter_resp;
  logic             acc_we;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic             acc_fault;
  logic [IDX_W-1:0] acc_idx;
  logic             commit_wr;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = 32'd0;
    err_d      = 1'b0;
    enter_resp = 1'b0;
    acc_we     = we_q;
    acc_addr   = addr_q;
    acc_wdata  = wdata_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
            acc_we     = we;
            acc_addr   = addr;
            acc_wdata  = wdata;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        // Any req seen here is dropped; acceptance resumes in the next IDLE cycle.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    acc_fault = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH));
    acc_idx   = acc_addr[IDX_W+1:2];
    commit_wr = enter_resp && acc_we && !acc_fault;

    // rdata and err are loaded only on the edge into RESP. They fall back
    // to zero on the following edge.
    if (enter_resp) begin
      err_d = acc_fault;
      if (!acc_we && !acc_fault) begin
        rdata_d = mem_q[acc_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Writes are blocked while reset is held. This also covers the
  // zero-wait-state case, where IDLE could otherwise commit straight from
  // the ports.
  always_ff @(posedge clk or negedge reset) begin
    if (reset && commit_wr) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign ack   = (state_q == RESP);
  assign busy  = (state_q != IDLE);
  assign rdata = rdata_q;
  assign err   = err_q;

`ifdef DMEM_TRAP_EN
  logic pass_q;
  logic fail_q;

  // Sticky flags that only reset clears. The flags are evaluated for every
  // write reaching RESP, including faulting writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if (enter_resp && acc_we) begin
      if (!acc_fault && (acc_addr == 32'd84) && (acc_wdata == 32'd7)) begin
        pass_q <= 1'b1;
      end
      if (acc_fault ||
          ((acc_addr != 32'd80) && (acc_addr != 32'd84)) ||
          ((acc_addr == 32'd84) && (acc_wdata != 32'd7))) begin
        fail_q <= 1'b1;
      end
    end
  end

  assign pass = pass_q;
  assign fail = fail_q;
`else
  assign pass = 1'b0;
  assign fail = 1'b0;
`endif

endmodule

`default_nettype wire
